// File: rtl/calc_pkg.sv
// Shared calculator definitions: sequencer state encoding, default operand
// geometry (also used by the ALU) and the index-width helper.
package calc_pkg;

   localparam int CALC_WIDTH        = 4;
   localparam int CALC_NUM_OPERANDS = 2;

   typedef enum logic {
      COLLECT = 1'b0,
      VALID   = 1'b1
   } seq_state_t;

   // Width of an operand index; at least one bit even for a single operand.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/operand_sequencer_if.sv
// Board-side and datapath-side signals of the operand sequencer.
// master: the sequencer itself; slave: the board I/O plus the ALU.
interface operand_sequencer_if import calc_pkg::*; #(
   parameter int WIDTH        = CALC_WIDTH,
   parameter int NUM_OPERANDS = CALC_NUM_OPERANDS
);
   localparam int IDXW = idx_width(NUM_OPERANDS);

   logic [WIDTH-1:0]              sw;
   logic                          sw_back;
   logic                          btn_confirm;
   logic                          btn_clear;
   logic                          consume;
   logic [NUM_OPERANDS*WIDTH-1:0] operands;
   logic [NUM_OPERANDS-1:0]       confirmed;
   logic [IDXW-1:0]               index;
   logic                          operands_valid;
   logic                          clear_pulse;

   modport master (
      input  sw, sw_back, btn_confirm, btn_clear, consume,
      output operands, confirmed, index, operands_valid, clear_pulse
   );

   modport slave (
      output sw, sw_back, btn_confirm, btn_clear, consume,
      input  operands, confirmed, index, operands_valid, clear_pulse
   );
endinterface

// File: rtl/button_conditioner.sv
// Raw push-button to single-cycle rising-edge pulse: 2-flop synchroniser,
// optional debounce (OPERAND_SEQ_DEBOUNCE_EN), registered edge detector.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_i,
   output logic rise_o
);
   logic sync1_q, sync2_q;
   logic lvl;
   logic prev_q, rise_q;

   // Two-stage synchroniser for the asynchronous button input.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

`ifdef OPERAND_SEQ_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          lvl_q, lvl_d;

   // Level follows the synchronised input only after it has disagreed for
   // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
   always_comb begin
      cnt_d = cnt_q;
      lvl_d = lvl_q;
      if (sync2_q == lvl_q) begin
         cnt_d = '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
         lvl_d = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Debounce counter and conditioned level registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         lvl_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         lvl_q <= lvl_d;
      end
   end

   assign lvl = lvl_q;
`else
   assign lvl = sync2_q;
`endif

   // Registered rising-edge detect so a held button fires exactly once.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         prev_q <= lvl;
         rise_q <= lvl & ~prev_q;
      end
   end

   assign rise_o = rise_q;

endmodule

// File: rtl/operand_sequencer.sv
// Operand sequencer: collects NUM_OPERANDS switch-entered operands through a
// confirm button (with step-back editing), hands them to the datapath via
// operands_valid/consume, and supports a soft clear button.
// Optional build macro: OPERAND_SEQ_DEBOUNCE_EN (per-button debounce).
module operand_sequencer import calc_pkg::*; #(
   parameter int WIDTH           = CALC_WIDTH,
   parameter int NUM_OPERANDS    = CALC_NUM_OPERANDS,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   operand_sequencer_if.master  bus
);
   localparam int IDXW = idx_width(NUM_OPERANDS);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_OPERANDS - 1);
   localparam int BTN_CFM = 0;
   localparam int BTN_CLR = 1;

   logic [1:0] btn_raw;
   logic [1:0] rise;

   seq_state_t                    state_q, state_d;
   logic [NUM_OPERANDS*WIDTH-1:0] ops_q, ops_d;
   logic [NUM_OPERANDS-1:0]       conf_q, conf_d;
   logic [IDXW-1:0]               idx_q, idx_d;
   logic                          clr_q, clr_d;

   assign btn_raw[BTN_CFM] = bus.btn_confirm;
   assign btn_raw[BTN_CLR] = bus.btn_clear;

   for (genvar b = 0; b < 2; b++) begin : g_btn
      button_conditioner #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_cond (
         .clk    (clk),
         .reset  (reset),
         .btn_i  (btn_raw[b]),
         .rise_o (rise[b])
      );
   end

   // Next state: clear beats consume beats confirm; losing confirms are dropped.
   always_comb begin
      state_d = state_q;
      ops_d   = ops_q;
      conf_d  = conf_q;
      idx_d   = idx_q;
      clr_d   = 1'b0;
      if (rise[BTN_CLR]) begin
         state_d = COLLECT;
         ops_d   = '0;
         conf_d  = '0;
         idx_d   = '0;
         clr_d   = 1'b1;
      end else begin
         case (state_q)
            COLLECT: begin
               if (rise[BTN_CFM]) begin
                  if (!bus.sw_back) begin
                     ops_d[int'(idx_q)*WIDTH +: WIDTH] = bus.sw;
                     conf_d[idx_q] = 1'b1;
                     if (idx_q == LAST_IDX) state_d = VALID;
                     else                   idx_d   = idx_q + 1'b1;
                  end else if (idx_q != '0) begin
                     // step back keeps the old operand value for re-entry
                     idx_d = idx_q - 1'b1;
                     conf_d[idx_q - 1'b1] = 1'b0;
                  end
               end
            end
            VALID: begin
               if (bus.consume) begin
                  state_d = COLLECT;
                  conf_d  = '0;
                  idx_d   = '0;
               end
            end
            default: state_d = COLLECT;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= COLLECT;
         ops_q   <= '0;
         conf_q  <= '0;
         idx_q   <= '0;
         clr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ops_q   <= ops_d;
         conf_q  <= conf_d;
         idx_q   <= idx_d;
         clr_q   <= clr_d;
      end
   end

   assign bus.operands       = ops_q;
   assign bus.confirmed      = conf_q;
   assign bus.index          = idx_q;
   assign bus.operands_valid = (state_q == VALID);
   assign bus.clear_pulse    = clr_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Self-checking bench for operand_sequencer: directed scenarios plus random
// button/consume traffic against an array-based reference model.
module tb_operand_sequencer;
   localparam int W  = 4;
   localparam int N  = 2;
   localparam int D  = 4;
   localparam int W3 = 8;
   localparam int N3 = 3;
   localparam int SETTLE = 16;
`ifdef OPERAND_SEQ_DEBOUNCE_EN
   localparam int LAT = 3 + D;
`else
   localparam int LAT = 3;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   operand_sequencer_if #(.WIDTH(W),  .NUM_OPERANDS(N))  bus  ();
   operand_sequencer_if #(.WIDTH(W3), .NUM_OPERANDS(N3)) bus3 ();

   operand_sequencer #(.WIDTH(W), .NUM_OPERANDS(N), .DEBOUNCE_CYCLES(D)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   operand_sequencer #(.WIDTH(W3), .NUM_OPERANDS(N3), .DEBOUNCE_CYCLES(D)) u_dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus3)
   );

   int total = 0;
   int bad   = 0;

   // reference model
   logic [W-1:0] m_ops [N];
   bit           m_conf [N];
   int           m_idx;
   bit           m_valid;
   int           clr_exp;
   int           clr_seen;

   always @(negedge clk) if (bus.clear_pulse === 1'b1) clr_seen++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic m_reset();
      for (int i = 0; i < N; i++) begin m_ops[i] = '0; m_conf[i] = 1'b0; end
      m_idx = 0; m_valid = 1'b0;
   endtask

   task automatic m_clear();
      m_reset();
      clr_exp++;
   endtask

   task automatic m_consume();
      if (m_valid) begin
         for (int i = 0; i < N; i++) m_conf[i] = 1'b0;
         m_idx = 0; m_valid = 1'b0;
      end
   endtask

   task automatic m_confirm(input logic [W-1:0] v, input bit back);
      if (!m_valid) begin
         if (!back) begin
            m_ops[m_idx] = v; m_conf[m_idx] = 1'b1;
            if (m_idx == N - 1) m_valid = 1'b1;
            else                m_idx++;
         end else if (m_idx > 0) begin
            m_idx--; m_conf[m_idx] = 1'b0;
         end
      end
   endtask

   task automatic check_all(input string t);
      logic [N*W-1:0] eo;
      logic [N-1:0]   ec;
      for (int i = 0; i < N; i++) begin eo[i*W +: W] = m_ops[i]; ec[i] = m_conf[i]; end
      chk({t, ".ops"},   32'(bus.operands),       32'(eo));
      chk({t, ".conf"},  32'(bus.confirmed),      32'(ec));
      chk({t, ".idx"},   32'(bus.index),          32'(m_idx));
      chk({t, ".valid"}, 32'(bus.operands_valid), 32'(m_valid));
   endtask

   task automatic do_reset(input int cyc);
      @(negedge clk); reset = 1'b1;
      repeat (cyc) @(negedge clk);
      reset = 1'b0;
      m_reset();
   endtask

   task automatic press(input bit c, input bit k, input int len);
      @(negedge clk); bus.btn_confirm = c; bus.btn_clear = k;
      repeat (len) @(posedge clk);
      @(negedge clk); bus.btn_confirm = 1'b0; bus.btn_clear = 1'b0;
      repeat (SETTLE) @(negedge clk);
   endtask

   task automatic confirm(input logic [W-1:0] v, input bit back);
      bus.sw = v; bus.sw_back = back;
      press(1'b1, 1'b0, 8);
      m_confirm(v, back);
      bus.sw_back = 1'b0;
   endtask

   task automatic clear_op(input bit with_cfm);
      press(with_cfm, 1'b1, 8);
      m_clear();
   endtask

   task automatic consume_op();
      @(negedge clk); bus.consume = 1'b1;
      @(negedge clk); bus.consume = 1'b0;
      repeat (2) @(negedge clk);
      m_consume();
   endtask

   // confirm latency from the first sampling edge, with release after 6 edges
   task automatic lat_test();
      logic [N-1:0] c0;
      int k;
      bit hit;
      c0 = bus.confirmed;
      @(negedge clk); bus.sw = 4'h9; bus.btn_confirm = 1'b1;
      @(posedge clk);
      k = 0; hit = 1'b0;
      while (!hit && k < 40) begin
         @(posedge clk); k++; #1;
         if (bus.confirmed !== c0) hit = 1'b1;
         if (k == 5) bus.btn_confirm = 1'b0;
      end
      bus.btn_confirm = 1'b0;
      chk("latency", 32'(k), 32'(LAT));
      repeat (SETTLE) @(negedge clk);
      m_confirm(4'h9, 1'b0);
   endtask

   initial begin
      reset = 1'b0;
      bus.sw = '0; bus.sw_back = 1'b0; bus.btn_confirm = 1'b0; bus.btn_clear = 1'b0; bus.consume = 1'b0;
      bus3.sw = '0; bus3.sw_back = 1'b0; bus3.btn_confirm = 1'b0; bus3.btn_clear = 1'b0; bus3.consume = 1'b0;
      clr_exp = 0; clr_seen = 0;

      // reset state
      do_reset(2);
      check_all("rst");
      chk("rst.clrp", 32'(bus.clear_pulse), 32'd0);

      // two operands, then an ignored third confirm
      confirm(4'hA, 1'b0);
      confirm(4'h3, 1'b0);
      chk("dir.ops", 32'(bus.operands), 32'h3A);
      chk("dir.conf", 32'(bus.confirmed), 32'h3);
      chk("dir.valid", 32'(bus.operands_valid), 32'd1);
      confirm(4'hF, 1'b0);
      check_all("third");

      // consume from VALID
      consume_op();
      check_all("consume");
      chk("consume.ops", 32'(bus.operands), 32'h3A);

      // step back and re-enter
      confirm(4'h5, 1'b0);
      check_all("sb1");
      confirm(4'h0, 1'b1);
      check_all("sb2");
      confirm(4'h0, 1'b1);
      check_all("sb_at0");
      confirm(4'h7, 1'b0);
      chk("sb.op0", 32'(bus.operands[3:0]), 32'h7);
      check_all("sb3");

      // consume in COLLECT is ignored
      consume_op();
      check_all("consume_collect");

      // short glitch
      clear_op(1'b0);
      bus.sw = 4'hC;
      press(1'b1, 1'b0, 2);
`ifndef OPERAND_SEQ_DEBOUNCE_EN
      m_confirm(4'hC, 1'b0);
`endif
      check_all("glitch");

      // latency and single latch
      clear_op(1'b0);
      lat_test();
      check_all("lat");

      // clear and confirm together mid-entry
      confirm(4'h4, 1'b0);
      bus.sw = 4'hE;
      clear_op(1'b1);
      check_all("clr_cfm");
      chk("clr_cnt", 32'(clr_seen), 32'(clr_exp));

      // reset with a confirm in flight
      confirm(4'h6, 1'b0);
      @(negedge clk); bus.btn_confirm = 1'b1;
      @(negedge clk); reset = 1'b1; bus.btn_confirm = 1'b0;
      @(negedge clk); reset = 1'b0;
      m_reset();
      repeat (SETTLE) @(negedge clk);
      check_all("rst_flight");

      // random traffic
      for (int it = 0; it < 50; it++) begin
         int op;
         op = $urandom_range(0, 9);
         if (op == 0)      clear_op(1'b0);
         else if (op == 1) clear_op(1'b1);
         else if (op <= 3) consume_op();
         else              confirm(W'($urandom), ($urandom_range(0, 3) == 0));
         check_all($sformatf("rnd%0d", it));
      end
      chk("rnd.clr_cnt", 32'(clr_seen), 32'(clr_exp));

      // three-operand, 8-bit instance
      for (int v = 1; v <= 3; v++) begin
         @(negedge clk); bus3.sw = W3'(v); bus3.btn_confirm = 1'b1;
         repeat (8) @(posedge clk);
         @(negedge clk); bus3.btn_confirm = 1'b0;
         repeat (SETTLE) @(negedge clk);
      end
      chk("n3.ops",   32'(bus3.operands),       32'h030201);
      chk("n3.conf",  32'(bus3.confirmed),      32'h7);
      chk("n3.idx",   32'(bus3.index),          32'd2);
      chk("n3.valid", 32'(bus3.operands_valid), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Parametrised front-end that collects `NUM_OPERANDS` switch-entered operands of `WIDTH` bits through a confirm button. It presents them to the calculator datapath with a valid/consume handshake. It sits between the board I/O (switches, BTNU/BTNL-style buttons) and the ALU. It adds synchronisation, optional debounce, step-back editing and soft clear.

## Interface
Parameters:
- `WIDTH`, 4: operand width in bits (≥1).
- `NUM_OPERANDS`, 2: operands per calculation (≥2).
- `DEBOUNCE_CYCLES`, 16: stable cycles required per button transition (used only with `OPERAND_SEQ_DEBOUNCE_EN`, ≥1).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous active-high reset. One clock; reset is synchronous and active-high.
- `sw` input WIDTH: operand value switches (quasi-static, not synchronised).
- `sw_back` input 1: step-back mode select (sw4 position).
- `btn_confirm` input 1: raw confirm button (BTNU).
- `btn_clear` input 1: raw soft-clear button (BTNL).
- `consume` input 1: datapath has taken the operands (one-cycle pulse).
- `operands` output NUM_OPERANDS*WIDTH: operand i occupies bits [i*WIDTH +: WIDTH].
- `confirmed` output NUM_OPERANDS: bit i set once operand i is latched.
- `index` output IDXW = max(1,$clog2(NUM_OPERANDS)): operand currently being entered.
- `operands_valid` output 1: all operands confirmed; held until `consume`.
- `clear_pulse` output 1: one-cycle pulse on each soft clear.

## Operation
- Each button passes through a 2-flop synchroniser and a rising-edge detector. Only rising edges act, so a held button acts once.
- States are COLLECT and VALID.
- COLLECT, confirm edge with `sw_back`=0:
  - `operands[index]` ← `sw` and `confirmed[index]` ← 1.
  - If `index` = NUM_OPERANDS-1, go to VALID and set `operands_valid`=1, with `index` unchanged.
  - Otherwise `index` ← `index`+1.
- COLLECT, confirm edge with `sw_back`=1:
  - If `index`>0: `index` ← `index`-1 and clear `confirmed[index-1]`. The operand value is retained.
  - If `index`=0: no effect.
- VALID: confirm edges are ignored.
- VALID, `consume`=1: clear `confirmed`, set `index` ← 0, set `operands_valid` ← 0, return to COLLECT. Operand values are retained.
- `consume` while in COLLECT is ignored.
- Clear edge in any state: `operands` ← 0, `confirmed` ← 0, `index` ← 0, `operands_valid` ← 0, go to COLLECT, and pulse `clear_pulse` for one cycle.
- Priority in the same cycle: `reset` > clear edge > `consume` > confirm edge. A confirm that loses is discarded, not deferred.
- No arithmetic beyond `index` increment and decrement, which are bounded and never wrap.

## Timing
- Reset values:
  - `operands`=0, `confirmed`=0, `index`=0, `operands_valid`=0, `clear_pulse`=0.
  - State COLLECT; synchroniser and edge flops 0; debounce counters 0.
- Without debounce: a button high first sampled at edge N updates the outputs after edge N+3 (2 sync + 1 register). `clear_pulse` is high in the cycle after edge N+3.
- With debounce: latency becomes N+3+DEBOUNCE_CYCLES. A glitch shorter than DEBOUNCE_CYCLES produces no action.
- `sw` is sampled on the edge that writes the operand.
- `operands_valid` rises on the same edge that sets the last `confirmed` bit. It falls on the edge that samples `consume`=1.
- Reset mid-entry or mid-VALID takes effect on the next edge and discards everything. Button edges in flight are lost.

## Configuration
- `OPERAND_SEQ_DEBOUNCE_EN` defined:
  - Each button gets a saturating counter.
  - The conditioned level changes only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - The counter resets on any agreement.
- Undefined: conditioned level = synchronised level. No counters are instantiated and `DEBOUNCE_CYCLES` is ignored.

## Structure
- `calc_pkg` holds:
  - the state enum `seq_state_t` (COLLECT, VALID);
  - the default `WIDTH` and `NUM_OPERANDS` constants shared with the ALU;
  - the helper function computing IDXW.
- Sub-module `button_conditioner`: synchroniser, optional debounce and rising-edge pulse. Instantiated once per button.

## Test plan
All scenarios use WIDTH=4, NUM_OPERANDS=2 and DEBOUNCE_CYCLES=4 with the macro defined, unless stated.
- Reset held 2 cycles -> all outputs 0, `index`=0.
- `sw`=4'hA, confirm; `sw`=4'h3, confirm -> `operands`=8'h3A, `confirmed`=2'b11, `operands_valid`=1; a third confirm changes nothing.
- From VALID, pulse `consume` -> `confirmed`=0, `index`=0, `operands_valid`=0, `operands` still 8'h3A.
- `sw`=4'h5, confirm (`index`=1); `sw_back`=1, confirm -> `index`=0, `confirmed`=2'b00; `sw_back`=0, `sw`=4'h7, confirm -> `operands[3:0]`=4'h7.
- 2-cycle glitch on `btn_confirm` -> no change; 6-cycle press -> exactly one latch, latency 7 edges. Without the macro, the same 2-cycle press latches after 3 edges.
- Clear and confirm edges in the same cycle mid-entry -> all cleared, `clear_pulse` high 1 cycle, no operand latched.
- Separate run with NUM_OPERANDS=3, WIDTH=8: three confirms (8'h01, 8'h02, 8'h03) -> `operands`=24'h030201, `operands_valid`=1.
